// File: rtl/nco_step_sequencer.sv
// Phase-step sequencer for the NCO: fixed, single sweep, triangle sweep and mute
// modes, delivering BASE_STEP * index over an AXI-Stream output with backpressure.
module nco_step_sequencer #(
    parameter int                   ACC_WIDTH   = 32,
    parameter int                   SEL_WIDTH   = 4,
    parameter logic [ACC_WIDTH-1:0] BASE_STEP   = ACC_WIDTH'(2748800),
    parameter int                   DWELL_WIDTH = 24
) (
    input  logic                   aclk,
    input  logic                   arst_n,
    input  logic [1:0]             cfg_mode,
    input  logic [SEL_WIDTH-1:0]   cfg_sel,
    input  logic [SEL_WIDTH-1:0]   cfg_stop_sel,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_start,
    output logic [ACC_WIDTH-1:0]   m_axis_step_tdata,
    output logic                   m_axis_step_tvalid,
    input  logic                   m_axis_step_tready,
    output logic [SEL_WIDTH-1:0]   cur_index,
    output logic                   busy,
    output logic                   sweep_done
);

    typedef enum logic [1:0] {S_FIXED, S_SWEEP, S_DONE, S_MUTE} state_t;

    state_t                 state;
    logic [SEL_WIDTH-1:0]   index_p0;
    logic [ACC_WIDTH-1:0]   step_p1;
    logic                   vld_p1;
    logic                   sweep_done_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [SEL_WIDTH-1:0]   start_q;
    logic [SEL_WIDTH-1:0]   stop_q;
    logic                   dir_up;
    logic                   pend_q;
    logic [SEL_WIDTH-1:0]   pend_sel;
    logic [SEL_WIDTH-1:0]   pend_stop;
    logic [DWELL_WIDTH-1:0] pend_dwell;

    // Product is formed at full width, then wrapped modulo 2^ACC_WIDTH.
    function automatic logic [ACC_WIDTH-1:0] wrap_step(input logic [SEL_WIDTH-1:0] idx);
        logic [ACC_WIDTH+SEL_WIDTH-1:0] full;
        full = {{SEL_WIDTH{1'b0}}, BASE_STEP} * {{ACC_WIDTH{1'b0}}, idx};
        return full[ACC_WIDTH-1:0];
    endfunction

    logic                   adv;
    logic                   sweep_mode;
    logic                   start_ok;
    logic                   go;
    logic [SEL_WIDTH-1:0]   go_sel;
    logic [SEL_WIDTH-1:0]   go_stop;
    logic [DWELL_WIDTH-1:0] go_dwell;
    logic [SEL_WIDTH-1:0]   nxt_index;
    logic [SEL_WIDTH-1:0]   hi_sel;
    logic [SEL_WIDTH-1:0]   lo_sel;

    assign adv        = !(vld_p1 && !m_axis_step_tready);
    assign sweep_mode = cfg_mode[0] ^ cfg_mode[1];
    assign start_ok   = cfg_start && sweep_mode;
    // A start captured during a stall is replayed on the first advancing cycle.
    assign go         = sweep_mode && (cfg_start || pend_q);
    assign go_sel     = cfg_start ? cfg_sel      : pend_sel;
    assign go_stop    = cfg_start ? cfg_stop_sel : pend_stop;
    assign go_dwell   = cfg_start ? cfg_dwell    : pend_dwell;
    assign nxt_index  = dir_up ? index_p0 + 1'b1 : index_p0 - 1'b1;
    assign hi_sel     = (stop_q > start_q) ? stop_q : start_q;
    assign lo_sel     = (stop_q > start_q) ? start_q : stop_q;

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state        <= S_FIXED;
            index_p0     <= '0;
            step_p1      <= '0;
            vld_p1       <= 1'b0;
            sweep_done_q <= 1'b0;
            dwell_cnt    <= '0;
            dwell_q      <= '0;
            start_q      <= '0;
            stop_q       <= '0;
            dir_up       <= 1'b1;
            pend_q       <= 1'b0;
            pend_sel     <= '0;
            pend_stop    <= '0;
            pend_dwell   <= '0;
        end else begin
            sweep_done_q <= 1'b0;
            vld_p1       <= 1'b1;
            if (adv) begin
                // Stage p0 -> p1: step word from the index chosen last cycle
                step_p1 <= wrap_step(index_p0);
                pend_q  <= 1'b0;
                if (go) begin
                    start_q   <= go_sel;
                    stop_q    <= go_stop;
                    dwell_q   <= go_dwell;
                    index_p0  <= go_sel;
                    dwell_cnt <= '0;
                    dir_up    <= (go_stop > go_sel);
                    if (go_stop == go_sel && cfg_mode == 2'b01) begin
                        state        <= S_DONE;
                        sweep_done_q <= 1'b1;
                    end else begin
                        state <= S_SWEEP;
                    end
                end else if (cfg_mode == 2'b00) begin
                    state    <= S_FIXED;
                    index_p0 <= cfg_sel;
                end else if (cfg_mode == 2'b11) begin
                    state    <= S_MUTE;
                    index_p0 <= '0;
                end else if (state == S_SWEEP) begin
                    if (dwell_cnt == dwell_q) begin
                        dwell_cnt <= '0;
                        if (start_q != stop_q) begin
                            index_p0 <= nxt_index;
                            if (cfg_mode == 2'b01) begin
                                if (nxt_index == stop_q) begin
                                    state        <= S_DONE;
                                    sweep_done_q <= 1'b1;
                                end
                            end else if (nxt_index == (dir_up ? hi_sel : lo_sel)) begin
                                dir_up <= !dir_up;
                            end
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
            end else if (start_ok) begin
                pend_q     <= 1'b1;
                pend_sel   <= cfg_sel;
                pend_stop  <= cfg_stop_sel;
                pend_dwell <= cfg_dwell;
            end
        end
    end

    assign m_axis_step_tdata  = step_p1;
    assign m_axis_step_tvalid = vld_p1;
    assign cur_index          = index_p0;
    assign busy               = (state == S_SWEEP);
    assign sweep_done         = sweep_done_q;

endmodule

// File: tb/tb_nco_step_sequencer.sv
// Directed bench for nco_step_sequencer: a default 32-bit instance and a 24-bit
// instance share stimulus; expected values are hand-computed constants.
module tb_nco_step_sequencer;

    localparam int BASE = 2748800;

    logic        aclk = 1'b0;
    logic        arst_n;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_sel;
    logic [3:0]  cfg_stop_sel;
    logic [23:0] cfg_dwell;
    logic        cfg_start;
    logic        tready;

    logic [31:0] tdata_a;
    logic        tvalid_a;
    logic [3:0]  cur_a;
    logic        busy_a;
    logic        done_a;
    logic [23:0] tdata_b;
    logic        tvalid_b;
    logic [3:0]  cur_b;
    logic        busy_b;
    logic        done_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 aclk = ~aclk;

    nco_step_sequencer dut_a (
        .aclk(aclk), .arst_n(arst_n), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
        .cfg_stop_sel(cfg_stop_sel), .cfg_dwell(cfg_dwell), .cfg_start(cfg_start),
        .m_axis_step_tdata(tdata_a), .m_axis_step_tvalid(tvalid_a),
        .m_axis_step_tready(tready), .cur_index(cur_a), .busy(busy_a),
        .sweep_done(done_a)
    );

    nco_step_sequencer #(.ACC_WIDTH(24), .BASE_STEP(24'd2748800)) dut_b (
        .aclk(aclk), .arst_n(arst_n), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
        .cfg_stop_sel(cfg_stop_sel), .cfg_dwell(cfg_dwell), .cfg_start(cfg_start),
        .m_axis_step_tdata(tdata_b), .m_axis_step_tvalid(tvalid_b),
        .m_axis_step_tready(tready), .cur_index(cur_b), .busy(busy_b),
        .sweep_done(done_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    int tri_exp [8] = '{1, 2, 3, 2, 1, 2, 3, 2};

    initial begin
        arst_n       = 1'b0;
        cfg_mode     = 2'b00;
        cfg_sel      = 4'd3;
        cfg_stop_sel = 4'd0;
        cfg_dwell    = 24'd0;
        cfg_start    = 1'b0;
        tready       = 1'b1;
        tick();
        tick();
        chk("rst_tvalid", tvalid_a, 0);
        chk("rst_tdata", tdata_a, 0);
        chk("rst_cur", cur_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);

        // Fixed mode out of reset
        arst_n = 1'b1;
        tick();
        chk("fix_tvalid", tvalid_a, 1);
        chk("fix_cur", cur_a, 3);
        tick();
        chk("fix_tdata", tdata_a, 8246400);

        // Single sweep 2 -> 5, dwell 3
        cfg_mode = 2'b01; cfg_sel = 4'd2; cfg_stop_sel = 4'd5; cfg_dwell = 24'd3; cfg_start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            cfg_start = 1'b0;
            chk($sformatf("ss_cur_k%0d", k), cur_a, (k <= 12) ? 2 + (k - 1) / 4 : 5);
            chk($sformatf("ss_busy_k%0d", k), busy_a, (k <= 12) ? 1 : 0);
            chk($sformatf("ss_done_k%0d", k), done_a, (k == 13) ? 1 : 0);
        end
        chk("ss_tdata_final", tdata_a, 13744000);

        // Restart the sweep from DONE, then stall it for 10 cycles
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("st_restart_cur", cur_a, 2);
        for (int k = 2; k <= 5; k++) tick();
        chk("st_pre_cur", cur_a, 3);
        chk("st_pre_tdata", tdata_a, 5497600);
        tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("st_hold_cur%0d", k), cur_a, 3);
            chk($sformatf("st_hold_tdata%0d", k), tdata_a, 5497600);
        end
        chk("st_hold_tvalid", tvalid_a, 1);
        tready = 1'b1;
        tick();
        chk("st_r1_cur", cur_a, 3);
        chk("st_r1_tdata", tdata_a, 8246400);
        tick();
        tick();
        chk("st_r3_cur", cur_a, 3);
        tick();
        chk("st_r4_cur", cur_a, 4);

        // Start during a stall with start == stop: latched, then DONE at once
        tready = 1'b0;
        cfg_sel = 4'd6; cfg_stop_sel = 4'd6; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_sel = 4'd0; cfg_stop_sel = 4'd0;
        tick();
        chk("ps_stall_cur", cur_a, 4);
        chk("ps_stall_busy", busy_a, 1);
        tready = 1'b1;
        tick();
        chk("ps_cur", cur_a, 6);
        chk("ps_done", done_a, 1);
        chk("ps_busy", busy_a, 0);
        tick();
        chk("ps_done_clr", done_a, 0);

        // Triangle sweep 1 <-> 3, dwell 0
        cfg_mode = 2'b10; cfg_sel = 4'd1; cfg_stop_sel = 4'd3; cfg_dwell = 24'd0; cfg_start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            cfg_start = 1'b0;
            chk($sformatf("tri_cur%0d", k), cur_a, tri_exp[k]);
            chk($sformatf("tri_done%0d", k), done_a, 0);
            chk($sformatf("tri_busy%0d", k), busy_a, 1);
        end

        // Abort to fixed index 7, then mute; 24-bit copy wraps
        cfg_mode = 2'b00; cfg_sel = 4'd7;
        tick();
        chk("ab_cur", cur_a, 7);
        chk("ab_busy", busy_a, 0);
        tick();
        chk("wr_tdata32", tdata_a, 19241600);
        chk("wr_tdata24", tdata_b, 2464384);
        cfg_mode = 2'b11;
        tick();
        chk("mu_cur", cur_a, 0);
        tick();
        chk("mu_tdata32", tdata_a, 0);
        chk("mu_tdata24", tdata_b, 0);

        // Reset in the middle of a sweep, then restart cleanly
        cfg_mode = 2'b01; cfg_sel = 4'd0; cfg_stop_sel = 4'd9; cfg_dwell = 24'd1; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick(); tick(); tick();
        chk("mr_busy_pre", busy_a, 1);
        chk("mr_cur_pre", cur_a, 1);
        arst_n = 1'b0;
        tick();
        chk("mr_tvalid", tvalid_a, 0);
        chk("mr_tdata", tdata_a, 0);
        chk("mr_cur", cur_a, 0);
        chk("mr_busy", busy_a, 0);
        chk("mr_done", done_a, 0);
        arst_n = 1'b1;
        tick();
        chk("mr_rel_tvalid", tvalid_a, 1);
        chk("mr_rel_cur", cur_a, 0);
        chk("mr_rel_busy", busy_a, 0);
        cfg_sel = 4'd4; cfg_stop_sel = 4'd3; cfg_dwell = 24'd0; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("rs_cur0", cur_a, 4);
        chk("rs_busy0", busy_a, 1);
        tick();
        chk("rs_cur1", cur_a, 3);
        chk("rs_done1", done_a, 1);
        chk("rs_busy1", busy_a, 0);
        tick();
        chk("rs_tdata", tdata_a, 8246400);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
